inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/branch_lut.sv | 40 ++++
 rtl/inst_fetch.sv | 110 +++++++++++
 tb/tb_inst_fetch.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// +----------------------------------------------------------------------+
// | cpu_pkg : shared fetch-unit widths, state encoding and branch helper  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package cpu_pkg;

  localparam int PC_WIDTH  = 10;
  localparam int LUT_DEPTH = 32;
  localparam int LUT_AW    = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  // Conditional branches are taken only when the datapath flag is set.
  function automatic logic branch_taken(input logic branch,
                                        input logic cond,
                                        input logic flag);
    return branch & (~cond | flag);
  endfunction

endpackage

`default_nettype wire

// File: rtl/branch_lut.sv
// +----------------------------------------------------------------------+
// | branch_lut : 32x10 branch target table, sync write/reset, async read  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module branch_lut
  import cpu_pkg::*;
#(
  parameter int DEPTH = LUT_DEPTH,
  parameter int AW    = LUT_AW,
  parameter int DW    = PC_WIDTH
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  // Reset wins over a coincident write, so that write is dropped.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/inst_fetch.sv
// +----------------------------------------------------------------------+
// | inst_fetch : PC sequencer with IDLE/RUN/HALT FSM and branch LUT;      |
// |   FETCH_BRANCH_REL_EN selects PC-relative LUT targets.  Revision 1.0  |
// +----------------------------------------------------------------------+
`default_nettype none

module inst_fetch
  import cpu_pkg::*;
(
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                Start,
  input  logic                Branch,
  input  logic                BranchCond,
  input  logic                Flag,
  input  logic [LUT_AW-1:0]   TargetIdx,
  input  logic                Ack,
  input  logic                LutWe,
  input  logic [LUT_AW-1:0]   LutAddr,
  input  logic [PC_WIDTH-1:0] LutData,
  output logic [PC_WIDTH-1:0] PC,
  output logic                Running,
  output logic                Done
);

  fetch_state_t        state_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic                running_q;
  logic                done_q;

  logic [PC_WIDTH-1:0] lut_rdata;
  logic [PC_WIDTH-1:0] branch_target;
  logic                take_branch;

  branch_lut #(
    .DEPTH (LUT_DEPTH),
    .AW    (LUT_AW),
    .DW    (PC_WIDTH)
  ) u_branch_lut (
    .clk_i   (Clk),
    .rst_ni  (Reset_n),
    .we_i    (LutWe),
    .waddr_i (LutAddr),
    .wdata_i (LutData),
    .raddr_i (TargetIdx),
    .rdata_o (lut_rdata)
  );

`ifdef FETCH_BRANCH_REL_EN
  // Entry is a signed offset; 10-bit addition wraps modulo 1024.
  assign branch_target = pc_q + lut_rdata;
`else
  assign branch_target = lut_rdata;
`endif

  assign take_branch = branch_taken(Branch, BranchCond, Flag);

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          pc_q <= '0;
          if (Start) begin
            state_q   <= RUN;
            running_q <= 1'b1;
            done_q    <= 1'b0;
          end
        end
        RUN: begin
          // Halt takes priority over any branch in the same cycle.
          if (Ack) begin
            state_q   <= HALT;
            running_q <= 1'b0;
            done_q    <= 1'b1;
          end else if (take_branch) begin
            pc_q <= branch_target;
          end else begin
            pc_q <= pc_q + 1'b1;
          end
        end
        HALT: begin
          if (Start) begin
            state_q   <= RUN;
            pc_q      <= '0;
            running_q <= 1'b1;
            done_q    <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          pc_q      <= '0;
          running_q <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign PC      = pc_q;
  assign Running = running_q;
  assign Done    = done_q;

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch.sv
// +----------------------------------------------------------------------+
// | tb_inst_fetch : directed vector bench for inst_fetch                  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_inst_fetch;

  logic       Clk = 1'b0;
  logic       Reset_n, Start, Branch, BranchCond, Flag, Ack, LutWe;
  logic [4:0] TargetIdx, LutAddr;
  logic [9:0] LutData;
  logic [9:0] PC;
  logic       Running, Done;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       rst_n, start, br, cond, flag, ack, we;
    logic [4:0] idx, waddr;
    logic [9:0] wdata;
    int         exp_pc;
    int         exp_run;
    int         exp_done;
  } vec_t;

  vec_t vecs[$];

  inst_fetch dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Start      (Start),
    .Branch     (Branch),
    .BranchCond (BranchCond),
    .Flag       (Flag),
    .TargetIdx  (TargetIdx),
    .Ack        (Ack),
    .LutWe      (LutWe),
    .LutAddr    (LutAddr),
    .LutData    (LutData),
    .PC         (PC),
    .Running    (Running),
    .Done       (Done)
  );

  always #5 Clk = ~Clk;

  function automatic vec_t mk(int rst_n, int start, int br, int cond, int flag, int idx,
                              int ack, int we, int wa, int wd, int epc, int erun, int edone);
    vec_t r;
    r.rst_n = 1'(rst_n); r.start = 1'(start); r.br = 1'(br); r.cond = 1'(cond);
    r.flag = 1'(flag); r.idx = 5'(idx); r.ack = 1'(ack); r.we = 1'(we);
    r.waddr = 5'(wa); r.wdata = 10'(wd);
    r.exp_pc = epc; r.exp_run = erun; r.exp_done = edone;
    return r;
  endfunction

  task automatic chk(string name, int idx, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    Reset_n = v.rst_n; Start = v.start; Branch = v.br; BranchCond = v.cond;
    Flag = v.flag; TargetIdx = v.idx; Ack = v.ack; LutWe = v.we;
    LutAddr = v.waddr; LutData = v.wdata;
  endtask

  task automatic step_check(vec_t v, int i);
    drive(v);
    @(posedge Clk);
    #1;
    chk("pc", i, int'(PC), v.exp_pc);
    chk("running", i, int'(Running), v.exp_run);
    chk("done", i, int'(Done), v.exp_done);
    chk("run_done_excl", i, int'(Running & Done), 0);
  endtask

  initial begin
    //           rst st br cd fl idx ak we wa  wd    pc  run dn
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,    0,    0, 0, 0));
`ifdef FETCH_BRANCH_REL_EN
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 'h3FE,  0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 2,    5,    0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0,    0,    0, 1, 0));
    for (int p = 1; p <= 5; p++)
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,    p, 1, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 1, 0, 0, 0,    0,    3, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,    0,    4, 1, 0));
    vecs.push_back(mk(1, 0, 1, 1, 1, 2, 0, 0, 0,    0,    9, 1, 0));
    vecs.push_back(mk(1, 0, 1, 1, 0, 2, 0, 0, 0,    0,   10, 1, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 2, 1, 0, 0,    0,   10, 0, 1));
`else
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,    0,    0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 1, 3, 0, 1, 3,  100,    0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 2,   40,    0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 5, 1020,    0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0,    0,    0, 1, 0));
    for (int p = 1; p <= 4; p++)
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,    p, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0,    0,    5, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,    0,    6, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,    0,    7, 1, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 3, 0, 0, 0,    0,  100, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,    0,  101, 1, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 6, 0, 1, 6,    8,    0, 1, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 6, 0, 0, 0,    0,    8, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,    0,    9, 1, 0));
    vecs.push_back(mk(1, 0, 1, 1, 0, 2, 0, 0, 0,    0,   10, 1, 0));
    vecs.push_back(mk(1, 0, 1, 1, 1, 2, 0, 0, 0,    0,   40, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 5, 0, 0, 0,    0,   41, 1, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 5, 0, 0, 0,    0, 1020, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,    0, 1021, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,    0, 1022, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,    0, 1023, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,    0,    0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 7,   20,    1, 1, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 7, 0, 0, 0,    0,   20, 1, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 3, 1, 0, 0,    0,   20, 0, 1));
    vecs.push_back(mk(1, 0, 1, 0, 0, 3, 0, 0, 0,    0,   20, 0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0,    0,    0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 8,   50,    1, 1, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 8, 0, 0, 0,    0,   50, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 3, 0, 1, 4,   77,    0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0,    0,    0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,    0,    1, 1, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 4, 0, 0, 0,    0,    0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,    0,    1, 1, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 3, 0, 0, 0,    0,    0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0,    0,    0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 9,    3,    0, 0, 1));
`endif

    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge Clk);
    #1;
    foreach (vecs[i]) step_check(vecs[i], i);

    // Straight-line run over the full address space: PC must wrap 1023 -> 0.
    begin
      int  first_bad = -1;
      int  bad_pc    = 0;
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(posedge Clk); #1;
      Reset_n = 1'b1; Start = 1'b1;
      @(posedge Clk); #1;
      Start = 1'b0;
      for (int c = 1; c <= 1030; c++) begin
        @(posedge Clk); #1;
        if (first_bad < 0 && int'(PC) != (c % 1024)) begin
          first_bad = c;
          bad_pc    = int'(PC);
        end
      end
      chk("wrap_run", first_bad, (first_bad < 0) ? 1030 % 1024 : bad_pc,
          (first_bad < 0) ? int'(PC) : first_bad % 1024);
      chk("wrap_final_pc", 1030, int'(PC), 1030 % 1024);
      chk("wrap_running", 1030, int'(Running), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
